muldiv_seq: RTL and testbench

Multi-cycle HI/LO multiply/divide sequencer for the pipelined MIPS datapath. It owns the HI and LO registers and executes MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO issued from the ID/EX stage. MULT/DIV run as a 32-step iterative radix-2 operation. The block back-pressures the pipeline with a ready/valid handshake instead of computing the full product combinationally in one cycle.

---
 rtl/muldiv_pkg.sv | 23 ++
 rtl/muldiv_iter.sv | 66 ++++++
 rtl/muldiv_seq.sv | 128 ++++++++++++
 tb/tb_muldiv_seq.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned STEPS = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MFHI  = 3'd4;
  localparam logic [2:0] OP_MFLO  = 3'd5;
  localparam logic [2:0] OP_MTHI  = 3'd6;
  localparam logic [2:0] OP_MTLO  = 3'd7;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

  // 0x80000000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic is_signed);
    return (is_signed && v[XLEN-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Radix-2 iteration datapath: MSB-first shift-add multiply, restoring shift-subtract divide.
module muldiv_iter
  import muldiv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic              div_mode,
  input  logic [XLEN-1:0]   opnd_in,
  input  logic [XLEN-1:0]   mq_in,
  output logic [2*XLEN-1:0] acc,
  output logic [XLEN-1:0]   mq,
  output logic              last
);

  localparam int unsigned CntW = $clog2(STEPS);
  localparam logic [CntW-1:0] LastCnt = CntW'(STEPS - 1);

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, mq_q, mq_d;
  logic [CntW-1:0]   cnt_q;
  logic [XLEN:0]     rem_shift, rem_diff;

  always_comb begin
    rem_shift = {acc_q[XLEN-1:0], mq_q[XLEN-1]};
    rem_diff  = rem_shift - {1'b0, opnd_q};
    acc_d     = acc_q;
    mq_d      = {mq_q[XLEN-2:0], 1'b0};
    if (div_mode) begin
      // Remainder lives in acc[31:0]; quotient bits shift into mq as dividend bits leave.
      if (!rem_diff[XLEN]) begin
        acc_d   = {{XLEN{1'b0}}, rem_diff[XLEN-1:0]};
        mq_d[0] = 1'b1;
      end else begin
        acc_d = {{XLEN{1'b0}}, rem_shift[XLEN-1:0]};
      end
    end else begin
      acc_d = {acc_q[2*XLEN-2:0], 1'b0}
            + (mq_q[XLEN-1] ? {{XLEN{1'b0}}, opnd_q} : {(2*XLEN){1'b0}});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      opnd_q <= '0;
      mq_q   <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      acc_q  <= '0;
      opnd_q <= opnd_in;
      mq_q   <= mq_in;
      cnt_q  <= '0;
    end else if (step) begin
      acc_q <= acc_d;
      mq_q  <= mq_d;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign acc  = acc_q;
  assign mq   = mq_q;
  assign last = (cnt_q == LastCnt);

endmodule

// File: rtl/muldiv_seq.sv
// HI/LO sequencer: owns HI/LO, serves MFxx/MTxx in one cycle, runs MULT/DIV over 33 cycles.
module muldiv_seq
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            op_valid,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            cancel,
  output logic            op_ready,
  output logic            busy,
  output logic [XLEN-1:0] rd_data,
  output logic            rd_valid,
  output logic            div_by_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  state_e            state_q;
  logic [XLEN-1:0]   hi_q, lo_q, rd_data_q;
  logic              rd_valid_q, dbz_q, neg_q, rneg_q, div_q;
  logic              accept, is_signed, is_mul, is_div, b_zero, start;
  logic [XLEN-1:0]   mag_a, mag_b, mq, quot, rem;
  logic [2*XLEN-1:0] acc, prod;
  logic              last;

  always_comb begin
    accept    = op_valid && (state_q == StIdle) && !cancel;
    is_signed = (op == OP_MULT) || (op == OP_DIV);
    is_mul    = (op == OP_MULT) || (op == OP_MULTU);
    is_div    = (op == OP_DIV) || (op == OP_DIVU);
    b_zero    = (src_b == '0);
    start     = accept && (is_mul || (is_div && !b_zero));
    mag_a     = mag(src_a, is_signed);
    mag_b     = mag(src_b, is_signed);
    prod      = neg_q ? -acc : acc;
    quot      = neg_q ? -mq : mq;
    rem       = rneg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  end

  muldiv_iter u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (start),
    .step     ((state_q == StMul) || (state_q == StDiv)),
    .div_mode (state_q == StDiv),
    .opnd_in  (is_div ? mag_b : mag_a),
    .mq_in    (is_div ? mag_a : mag_b),
    .acc      (acc),
    .mq       (mq),
    .last     (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      hi_q       <= '0;
      lo_q       <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      dbz_q      <= 1'b0;
      neg_q      <= 1'b0;
      rneg_q     <= 1'b0;
      div_q      <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      dbz_q      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            unique case (op)
              OP_MTHI: hi_q <= src_a;
              OP_MTLO: lo_q <= src_a;
              OP_MFHI: begin
                rd_data_q  <= hi_q;
                rd_valid_q <= 1'b1;
              end
              OP_MFLO: begin
                rd_data_q  <= lo_q;
                rd_valid_q <= 1'b1;
              end
              OP_MULT, OP_MULTU: begin
                neg_q   <= is_signed && (src_a[XLEN-1] ^ src_b[XLEN-1]);
                rneg_q  <= 1'b0;
                div_q   <= 1'b0;
                state_q <= StMul;
              end
              OP_DIV, OP_DIVU: begin
                if (b_zero) begin
                  dbz_q <= 1'b1;
                end else begin
                  neg_q   <= is_signed && (src_a[XLEN-1] ^ src_b[XLEN-1]);
                  rneg_q  <= is_signed && src_a[XLEN-1];
                  div_q   <= 1'b1;
                  state_q <= StDiv;
                end
              end
              default: ;
            endcase
          end
        end
        StMul, StDiv: begin
          if (cancel) state_q <= StIdle;
          else if (last) state_q <= StFix;
        end
        StFix: begin
          if (!cancel) begin
            hi_q <= div_q ? rem : prod[2*XLEN-1:XLEN];
            lo_q <= div_q ? quot : prod[XLEN-1:0];
          end
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign op_ready    = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: cycle model with arithmetic reference plus directed cases.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic        clk, rst_n, op_valid, cancel;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic        op_ready, busy, rd_valid, div_by_zero;
  logic [31:0] rd_data, hi, lo;

  int checks = 0;
  int errors = 0;
  logic chk_en;

  // Model state: remaining busy cycles, architectural HI/LO, read port, pending result.
  int          m_rem;
  logic [31:0] m_hi, m_lo, m_rd, p_hi, p_lo;
  logic        m_rdv, m_dbz;

  muldiv_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op_valid    (op_valid),
    .op          (op),
    .src_a       (src_a),
    .src_b       (src_b),
    .cancel      (cancel),
    .op_ready    (op_ready),
    .busy        (busy),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns {hi, lo} for MULT/MULTU/DIV/DIVU from plain integer arithmetic.
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    case (o)
      OP_MULT:  p = 64'(sa * sb);
      OP_MULTU: p = {32'b0, a} * {32'b0, b};
      OP_DIV:   p = {32'(sa % sb), 32'(sa / sb)};
      OP_DIVU:  p = {a % b, a / b};
      default:  p = '0;
    endcase
    return p;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem <= 0;
      m_hi  <= '0;
      m_lo  <= '0;
      m_rd  <= '0;
      m_rdv <= 1'b0;
      m_dbz <= 1'b0;
      p_hi  <= '0;
      p_lo  <= '0;
    end else begin
      m_rdv <= 1'b0;
      m_dbz <= 1'b0;
      if (m_rem != 0) begin
        if (cancel) begin
          m_rem <= 0;
        end else begin
          m_rem <= m_rem - 1;
          if (m_rem == 1) begin
            m_hi <= p_hi;
            m_lo <= p_lo;
          end
        end
      end else if (op_valid && !cancel) begin
        case (op)
          OP_MTHI: m_hi <= src_a;
          OP_MTLO: m_lo <= src_a;
          OP_MFHI: begin m_rd <= m_hi; m_rdv <= 1'b1; end
          OP_MFLO: begin m_rd <= m_lo; m_rdv <= 1'b1; end
          default: begin
            if ((op == OP_DIV || op == OP_DIVU) && src_b == 32'd0) begin
              m_dbz <= 1'b1;
            end else begin
              {p_hi, p_lo} <= ref_result(op, src_a, src_b);
              m_rem        <= 33;
            end
          end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("op_ready", {31'b0, op_ready}, {31'b0, m_rem == 0});
      cmp("busy", {31'b0, busy}, {31'b0, m_rem != 0});
      cmp("hi", hi, m_hi);
      cmp("lo", lo, m_lo);
      cmp("rd_valid", {31'b0, rd_valid}, {31'b0, m_rdv});
      cmp("rd_data", rd_data, m_rd);
      cmp("div_by_zero", {31'b0, div_by_zero}, {31'b0, m_dbz});
    end
  end

  // Call and return just after a rising edge; waited counts cycles op_ready was low.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int waited);
    logic rdy;
    rdy      = 1'b0;
    op_valid = 1'b1;
    op       = o;
    src_a    = a;
    src_b    = b;
    waited   = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      rdy = op_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      waited++;
    end
    op_valid = 1'b0;
    cmp("accept within bound", {31'b0, rdy}, 32'd1);
  endtask

  task automatic wait_idle(output int busy_cycles);
    logic b;
    busy_cycles = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      b = busy;
      @(posedge clk);
      #1;
      if (!b) break;
      busy_cycles++;
    end
  endtask

  task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int w, bc;
    issue(o, a, b, w);
    wait_idle(bc);
    cmp({nm, " busy cycles"}, 32'(bc), 32'd33);
    cmp({nm, " hi"}, hi, exp_hi);
    cmp({nm, " lo"}, lo, exp_lo);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r;
    int          w;
    rst_n    = 1'b0;
    op_valid = 1'b0;
    op       = '0;
    src_a    = '0;
    src_b    = '0;
    cancel   = 1'b0;
    chk_en   = 1'b0;

    // Pin the reference arithmetic with hand-computed values.
    r = ref_result(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    cmp("model MULT hi", r[63:32], 32'hFFFF_FFFF);
    cmp("model MULT lo", r[31:0], 32'hFFFF_FFFA);
    r = ref_result(OP_MULTU, 32'hFFFF_FFFE, 32'd3);
    cmp("model MULTU hi", r[63:32], 32'h0000_0002);
    r = ref_result(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    cmp("model DIV q", r[31:0], 32'hFFFF_FFFD);
    cmp("model DIV r", r[63:32], 32'hFFFF_FFFF);
    r = ref_result(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    cmp("model DIV wrap q", r[31:0], 32'h8000_0000);
    cmp("model DIV wrap r", r[63:32], 32'h0000_0000);

    repeat (3) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    cmp("reset hi", hi, 32'd0);
    cmp("reset lo", lo, 32'd0);
    cmp("reset op_ready", {31'b0, op_ready}, 32'd1);
    cmp("reset busy", {31'b0, busy}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    run_op("MULT", OP_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("MULTU", OP_MULTU, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA);
    run_op("DIV neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("DIVU", OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3);
    run_op("DIV wrap", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

    // Divide by zero: single pulse, no busy, HI/LO untouched.
    issue(OP_DIV, 32'd5, 32'd0, w);
    @(negedge clk);
    cmp("dbz pulse", {31'b0, div_by_zero}, 32'd1);
    cmp("dbz op_ready", {31'b0, op_ready}, 32'd1);
    cmp("dbz busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    cmp("dbz pulse end", {31'b0, div_by_zero}, 32'd0);
    cmp("dbz lo kept", lo, 32'h8000_0000);
    @(posedge clk);
    #1;

    // MFLO held behind a MULT waits out all 33 busy cycles, then returns the new LO.
    issue(OP_MULT, 32'd3, 32'd4, w);
    issue(OP_MFLO, 32'd0, 32'd0, w);
    cmp("MFLO wait cycles", 32'(w), 32'd33);
    @(negedge clk);
    cmp("MFLO rd_valid", {31'b0, rd_valid}, 32'd1);
    cmp("MFLO rd_data", rd_data, 32'd12);
    @(posedge clk);
    #1;

    // MTHI then a cancelled MULT: HI keeps the moved value.
    issue(OP_MTHI, 32'h0000_1234, 32'd0, w);
    issue(OP_MULT, 32'd7, 32'd9, w);
    repeat (9) @(posedge clk);
    #1 cancel = 1'b1;
    @(posedge clk);
    #1 cancel = 1'b0;
    @(negedge clk);
    cmp("cancel idle", {31'b0, op_ready}, 32'd1);
    cmp("cancel hi", hi, 32'h0000_1234);
    repeat (40) @(posedge clk);
    #1;
    cmp("cancel hi later", hi, 32'h0000_1234);
    cmp("cancel lo later", lo, 32'd12);

    // Asynchronous reset in the middle of a divide.
    issue(OP_DIV, 32'd100, 32'd7, w);
    repeat (20) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    cmp("async rst busy", {31'b0, busy}, 32'd0);
    cmp("async rst op_ready", {31'b0, op_ready}, 32'd1);
    cmp("async rst hi", hi, 32'd0);
    cmp("async rst rd_data", rd_data, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_op("MULT after reset", OP_MULT, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFB);

    // Random traffic, including ops offered while busy and occasional flushes.
    for (int c = 0; c < 4000; c++) begin
      op_valid = ($urandom_range(0, 1) == 1);
      op       = 3'($urandom_range(0, 7));
      src_a    = pick();
      src_b    = pick();
      cancel   = ($urandom_range(0, 47) == 0);
      @(posedge clk);
      #1;
    end
    op_valid = 1'b0;
    cancel   = 1'b0;
    repeat (40) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
